// File: rtl/cmac_wt_shadow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cmac_wt_shadow_ctrl_if
// Description : Bundles the retimed weight/data input streams and the
//               aligned data/active-weight outputs of cmac_wt_shadow_ctrl.
//               master : producer/consumer side (drives wt_in_*/dat_in_*)
//               slave  : the shadow controller itself
// Revision    : 1.0 - initial release
// ============================================================================
interface cmac_wt_shadow_ctrl_if #(
    parameter int ATOMC    = 8,
    parameter int BPE      = 8,
    parameter int ATOMK_HF = 4,
    parameter int CNT_W    = 16
);
    // weight stream
    logic                         wt_in_pvld;
    logic [ATOMC-1:0]             wt_in_mask;
    logic [ATOMC*BPE-1:0]         wt_in_data;
    logic [ATOMK_HF-1:0]          wt_in_sel;
    // data stream
    logic                         dat_in_pvld;
    logic [ATOMC-1:0]             dat_in_mask;
    logic [ATOMC*BPE-1:0]         dat_in_data;
    logic [8:0]                   dat_in_pd;
    // aligned outputs
    logic                         dat_out_pvld;
    logic [ATOMC-1:0]             dat_out_mask;
    logic [ATOMC*BPE-1:0]         dat_out_data;
    logic [8:0]                   dat_out_pd;
    logic [ATOMK_HF*ATOMC*BPE-1:0] wt_act_data;
    logic [ATOMK_HF*ATOMC-1:0]    wt_act_mask;
    logic [ATOMK_HF-1:0]          wt_act_vld;
    logic [CNT_W-1:0]             stripe_cnt;
    logic                         wt_ovf_err;

    modport master (
        output wt_in_pvld, wt_in_mask, wt_in_data, wt_in_sel,
        output dat_in_pvld, dat_in_mask, dat_in_data, dat_in_pd,
        input  dat_out_pvld, dat_out_mask, dat_out_data, dat_out_pd,
        input  wt_act_data, wt_act_mask, wt_act_vld, stripe_cnt, wt_ovf_err
    );

    modport slave (
        input  wt_in_pvld, wt_in_mask, wt_in_data, wt_in_sel,
        input  dat_in_pvld, dat_in_mask, dat_in_data, dat_in_pd,
        output dat_out_pvld, dat_out_mask, dat_out_data, dat_out_pd,
        output wt_act_data, wt_act_mask, wt_act_vld, stripe_cnt, wt_ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/cmac_wt_shadow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cmac_wt_shadow_ctrl
// Description : CMAC weight shadow controller. Weight packets are written
//               into per-cell shadow banks; a stripe-start data beat promotes
//               every loaded shadow to the active weights on the same edge
//               that registers the beat, so each data beat leaves aligned
//               with the weights it multiplies against.
// Ports       : nvdla_core_clk  - core clock
//               nvdla_core_rstn - asynchronous active-low reset
//               bus (slave)     - wt_in_*/dat_in_* inputs, dat_out_*,
//                                 wt_act_*, stripe_cnt, wt_ovf_err outputs
// Revision    : 1.0 - initial release
// ============================================================================
module cmac_wt_shadow_ctrl #(
    parameter int ATOMC    = 8,
    parameter int BPE      = 8,
    parameter int ATOMK_HF = 4,
    parameter int CNT_W    = 16
) (
    input  wire logic             nvdla_core_clk,
    input  wire logic             nvdla_core_rstn,
    cmac_wt_shadow_ctrl_if.slave  bus
);

    logic [ATOMK_HF-1:0][ATOMC-1:0][BPE-1:0] r_shadow;
    logic [ATOMK_HF-1:0][ATOMC-1:0]          r_shadow_mask;
    logic [ATOMK_HF-1:0]                     r_loaded;
    logic [ATOMK_HF-1:0][ATOMC-1:0][BPE-1:0] r_act_data;
    logic [ATOMK_HF-1:0][ATOMC-1:0]          r_act_mask;
    logic [ATOMK_HF-1:0]                     r_act_vld;
    logic                                    r_ovf_err;
    logic [CNT_W-1:0]                        r_stripe_cnt;
    logic                                    r_dat_pvld;
    logic [ATOMC-1:0]                        r_dat_mask;
    logic [ATOMC-1:0][BPE-1:0]               r_dat_data;
    logic [8:0]                              r_dat_pd;

    logic [ATOMC-1:0][BPE-1:0] w_wt_data;
    logic [ATOMC-1:0][BPE-1:0] w_dat_data;
    logic [ATOMK_HF-1:0]       w_wr_sel;
    logic                      w_promote;
    logic                      w_stripe_end;
    logic                      w_layer_end;
    logic                      w_ovf_hit;

    assign w_wt_data    = bus.wt_in_data;
    assign w_dat_data   = bus.dat_in_data;
    assign w_wr_sel     = {ATOMK_HF{bus.wt_in_pvld}} & bus.wt_in_sel;
    assign w_promote    = bus.dat_in_pvld & bus.dat_in_pd[6];
    assign w_stripe_end = bus.dat_in_pvld & bus.dat_in_pd[7];
    assign w_layer_end  = bus.dat_in_pvld & bus.dat_in_pd[8];
    // A promotion in the same cycle drains every loaded shadow first, so a
    // write into a loaded cell is only an overflow when no promotion occurs.
    assign w_ovf_hit    = (|(w_wr_sel & r_loaded)) & ~w_promote;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_shadow      <= '0;
            r_shadow_mask <= '0;
            r_loaded      <= '0;
            r_act_data    <= '0;
            r_act_mask    <= '0;
            r_act_vld     <= '0;
            r_ovf_err     <= 1'b0;
            r_stripe_cnt  <= '0;
            r_dat_pvld    <= 1'b0;
            r_dat_mask    <= '0;
            r_dat_data    <= '0;
            r_dat_pd      <= '0;
        end else begin
            for (int c = 0; c < ATOMK_HF; c++) begin
                // Promotion reads the pre-edge shadow, so a same-cycle write
                // to this cell is not seen until the next promotion.
                if (w_promote && r_loaded[c]) begin
                    r_act_data[c] <= r_shadow[c];
                    r_act_mask[c] <= r_shadow_mask[c];
                    r_act_vld[c]  <= 1'b1;
                end
                if (w_wr_sel[c]) begin
                    for (int k = 0; k < ATOMC; k++) begin
                        if (bus.wt_in_mask[k]) begin
                            r_shadow[c][k] <= w_wt_data[k];
                        end
                    end
                    r_shadow_mask[c] <= bus.wt_in_mask;
                    r_loaded[c]      <= 1'b1;
                end else if (w_promote) begin
                    r_loaded[c] <= 1'b0;
                end
            end

            // Layer end overrides any same-cycle promotion's valid set.
            if (w_layer_end) begin
                r_act_vld <= '0;
            end

            if (w_ovf_hit) begin
                r_ovf_err <= 1'b1;
            end

            if (w_layer_end) begin
                r_stripe_cnt <= '0;
            end else if (w_stripe_end) begin
                r_stripe_cnt <= r_stripe_cnt + CNT_W'(1);
            end

            r_dat_pvld <= bus.dat_in_pvld;
            if (bus.dat_in_pvld) begin
                r_dat_mask <= bus.dat_in_mask;
                r_dat_pd   <= bus.dat_in_pd;
                for (int k = 0; k < ATOMC; k++) begin
                    if (bus.dat_in_mask[k]) begin
                        r_dat_data[k] <= w_dat_data[k];
                    end
                end
            end
        end
    end

    assign bus.dat_out_pvld = r_dat_pvld;
    assign bus.dat_out_mask = r_dat_mask;
    assign bus.dat_out_data = r_dat_data;
    assign bus.dat_out_pd   = r_dat_pd;
    assign bus.wt_act_data  = r_act_data;
    assign bus.wt_act_mask  = r_act_mask;
    assign bus.wt_act_vld   = r_act_vld;
    assign bus.stripe_cnt   = r_stripe_cnt;
    assign bus.wt_ovf_err   = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_cmac_wt_shadow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmac_wt_shadow_ctrl
// Description : Directed self-checking bench for cmac_wt_shadow_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmac_wt_shadow_ctrl;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    cmac_wt_shadow_ctrl_if #(.ATOMC(8), .BPE(8), .ATOMK_HF(4), .CNT_W(16)) bus ();

    cmac_wt_shadow_ctrl #(.ATOMC(8), .BPE(8), .ATOMK_HF(4), .CNT_W(16)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wt(input logic [3:0] sel, input logic [7:0] mask, input logic [63:0] data);
        bus.wt_in_pvld = 1'b1;
        bus.wt_in_sel  = sel;
        bus.wt_in_mask = mask;
        bus.wt_in_data = data;
    endtask

    task automatic wt_idle();
        bus.wt_in_pvld = 1'b0;
        bus.wt_in_sel  = '0;
        bus.wt_in_mask = '0;
        bus.wt_in_data = '0;
    endtask

    task automatic dat(input logic [8:0] pd, input logic [7:0] mask, input logic [63:0] data);
        bus.dat_in_pvld = 1'b1;
        bus.dat_in_pd   = pd;
        bus.dat_in_mask = mask;
        bus.dat_in_data = data;
    endtask

    task automatic dat_idle();
        bus.dat_in_pvld = 1'b0;
        bus.dat_in_pd   = '0;
        bus.dat_in_mask = '0;
        bus.dat_in_data = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        wt_idle();
        dat_idle();
        repeat (3) cyc();

        // reset state
        chk("rst_pvld",  bus.dat_out_pvld, 0);
        chk("rst_vld",   bus.wt_act_vld,   0);
        chk("rst_act",   bus.wt_act_data,  0);
        chk("rst_cnt",   bus.stripe_cnt,   0);
        chk("rst_ovf",   bus.wt_ovf_err,   0);
        rstn = 1'b1;
        cyc();

        // basic load and promote of cell 0
        wt(4'b0001, 8'hFF, 64'h0807060504030201);
        cyc();
        wt_idle();
        dat(9'h040, 8'hFF, 64'hDEADBEEF01234567);
        cyc();
        dat_idle();
        chk("t1_pvld", bus.dat_out_pvld, 1);
        chk("t1_pd",   bus.dat_out_pd,   9'h040);
        chk("t1_data", bus.dat_out_data, 64'hDEADBEEF01234567);
        chk("t1_vld",  bus.wt_act_vld,   4'b0001);
        chk("t1_act",  bus.wt_act_data,  256'h0807060504030201);
        chk("t1_ovf",  bus.wt_ovf_err,   0);
        cyc();
        chk("t1_pvld_drop", bus.dat_out_pvld, 0);

        // double write to cell 1 without promotion
        wt(4'b0010, 8'hFF, 64'hAAAAAAAAAAAAAAAA);
        cyc();
        wt(4'b0010, 8'hFF, 64'h5555555555555555);
        cyc();
        wt_idle();
        chk("t2_ovf", bus.wt_ovf_err, 1);
        cyc();
        chk("t2_ovf_sticky", bus.wt_ovf_err, 1);
        dat(9'h040, 8'hFF, 64'h0);
        cyc();
        dat_idle();
        chk("t2_act", bus.wt_act_data,
            {64'h0, 64'h0, 64'h5555555555555555, 64'h0807060504030201});
        chk("t2_vld", bus.wt_act_vld, 4'b0011);

        // partial-mask write over an existing shadow in cell 2
        wt(4'b0100, 8'hFF, 64'h2222222222222222);
        cyc();
        wt_idle();
        dat(9'h040, 8'hFF, 64'hA1A2A3A4A5A6A7A8);
        cyc();
        dat_idle();
        wt(4'b0100, 8'h0F, 64'h1111111111111111);
        cyc();
        wt_idle();
        dat(9'h040, 8'h0F, 64'h0);
        cyc();
        dat_idle();
        chk("t3_act", bus.wt_act_data,
            {64'h0, 64'h2222222211111111, 64'h5555555555555555, 64'h0807060504030201});
        chk("t3_mask", bus.wt_act_mask, 32'h000FFFFF);
        chk("t3_vld",  bus.wt_act_vld,  4'b0111);
        chk("t3_dat_hold", bus.dat_out_data, 64'hA1A2A3A4_00000000);
        chk("t3_dat_mask", bus.dat_out_mask, 8'h0F);

        // reset pulse clears sticky error
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        chk("rp_ovf", bus.wt_ovf_err, 0);
        chk("rp_act", bus.wt_act_data, 0);

        // same-cycle write and promotion on cell 3
        wt(4'b1000, 8'hFF, 64'h4444444444444444);
        cyc();
        wt(4'b1000, 8'hFF, 64'h3333333333333333);
        dat(9'h040, 8'hFF, 64'h0);
        cyc();
        wt_idle();
        chk("t4_act", bus.wt_act_data, {64'h4444444444444444, 192'h0});
        chk("t4_vld", bus.wt_act_vld,  4'b1000);
        chk("t4_ovf", bus.wt_ovf_err,  0);
        cyc();
        dat_idle();
        chk("t4_act2", bus.wt_act_data, {64'h3333333333333333, 192'h0});
        chk("t4_ovf2", bus.wt_ovf_err,  0);

        // sel=0 write is dropped
        wt(4'b0000, 8'hFF, 64'h7777777777777777);
        cyc();
        wt_idle();
        dat(9'h040, 8'hFF, 64'h0);
        cyc();
        dat_idle();
        chk("t5_act", bus.wt_act_data, {64'h3333333333333333, 192'h0});
        chk("t5_vld", bus.wt_act_vld,  4'b1000);
        chk("t5_ovf", bus.wt_ovf_err,  0);

        // stripe counting and layer end
        dat(9'h080, 8'hFF, 64'h0);
        cyc();
        chk("t6_cnt1", bus.stripe_cnt, 1);
        cyc();
        chk("t6_cnt2", bus.stripe_cnt, 2);
        cyc();
        chk("t6_cnt3", bus.stripe_cnt, 3);
        dat(9'h180, 8'hFF, 64'h0);
        cyc();
        dat_idle();
        chk("t6_cnt0", bus.stripe_cnt, 0);
        chk("t6_vld",  bus.wt_act_vld, 0);
        chk("t6_pd",   bus.dat_out_pd, 9'h180);

        // layer end with same-cycle promotion: data promoted, valid cleared
        wt(4'b0001, 8'hFF, 64'h0807060504030201);
        cyc();
        wt_idle();
        dat(9'h140, 8'hFF, 64'h0);
        cyc();
        dat_idle();
        chk("t7_act", bus.wt_act_data, {64'h3333333333333333, 128'h0, 64'h0807060504030201});
        chk("t7_vld", bus.wt_act_vld,  0);

        // counter wrap
        dat(9'h080, 8'hFF, 64'h0);
        repeat (65535) @(posedge clk);
        #1;
        chk("t8_cnt_max", bus.stripe_cnt, 16'hFFFF);
        cyc();
        dat_idle();
        chk("t8_cnt_wrap", bus.stripe_cnt, 0);

        // asynchronous reset mid-stream
        wt(4'b0001, 8'hFF, 64'h0807060504030201);
        cyc();
        wt_idle();
        dat(9'h0C0, 8'hFF, 64'h0000000000000001);
        cyc();
        dat_idle();
        chk("t9_cnt", bus.stripe_cnt, 1);
        chk("t9_vld", bus.wt_act_vld, 4'b0001);
        #2;
        rstn = 1'b0;
        #1;
        chk("t9_ar_pvld", bus.dat_out_pvld, 0);
        chk("t9_ar_data", bus.dat_out_data, 0);
        chk("t9_ar_pd",   bus.dat_out_pd,   0);
        chk("t9_ar_act",  bus.wt_act_data,  0);
        chk("t9_ar_mask", bus.wt_act_mask,  0);
        chk("t9_ar_vld",  bus.wt_act_vld,   0);
        chk("t9_ar_cnt",  bus.stripe_cnt,   0);
        cyc();
        rstn = 1'b1;
        dat(9'h040, 8'hFF, 64'h0);
        cyc();
        dat_idle();
        chk("t9_post_pvld", bus.dat_out_pvld, 1);
        chk("t9_post_vld",  bus.wt_act_vld,   0);
        chk("t9_post_act",  bus.wt_act_data,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmac_wt_shadow_ctrl.md
Name: cmac_wt_shadow_ctrl

Overview:
- First stage inside CMAC, directly downstream of the CSC-to-CMAC retiming pipe; consumes its retimed weight and data streams.
- Weight packets land in per-cell shadow banks. On a stripe-start data beat, all loaded shadows are promoted to active weights.
- Data beats are registered one cycle so each beat leaves aligned with the active weights it must multiply against.

Parameters:
- ATOMC, 8, elements per atom; mask width.
- BPE, 8, bits per element.
- ATOMK_HF, 4, MAC cells; width of the one-hot weight select.
- CNT_W, 16, stripe counter width.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  async active-low reset.
- wt_in_pvld  in  1  weight beat valid.
- wt_in_mask  in  ATOMC  per-element write enable.
- wt_in_data  in  ATOMC*BPE  weight elements; element k is at [k*BPE +: BPE].
- wt_in_sel  in  ATOMK_HF  target cell(s), one-hot.
- dat_in_pvld  in  1  data beat valid.
- dat_in_mask  in  ATOMC  per-element valid.
- dat_in_data  in  ATOMC*BPE  data elements.
- dat_in_pd  in  9  [5:0] tag, [6] stripe_st, [7] stripe_end, [8] layer_end.
- dat_out_pvld  out  1  registered data valid.
- dat_out_mask  out  ATOMC  registered mask.
- dat_out_data  out  ATOMC*BPE  registered data.
- dat_out_pd  out  9  registered pd.
- wt_act_data  out  ATOMK_HF*ATOMC*BPE  active weights; cell c, element k at [(c*ATOMC+k)*BPE +: BPE].
- wt_act_mask  out  ATOMK_HF*ATOMC  active masks.
- wt_act_vld  out  ATOMK_HF  per-cell active weights valid.
- stripe_cnt  out  CNT_W  stripes completed in current layer.
- wt_ovf_err  out  1  sticky: shadow overwritten before promotion.

Behaviour:
- Interface: one clock, nvdla_core_clk. Reset nvdla_core_rstn is asynchronous, active-low.
- Reset: every output, shadow bank, shadow mask and shadow-loaded flag clears to 0.
- No backpressure: both inputs are accepted every valid cycle.
- Weight write (wt_in_pvld=1):
  - For each cell c with wt_in_sel[c]=1: shadow element k is written only when wt_in_mask[k]=1; unmasked elements hold.
  - shadow_mask[c] is written with the full wt_in_mask.
  - loaded[c] is set.
- Select handling: sel=0 means the write is dropped with no state change. Multiple sel bits mean all selected cells are written (legal).
- Overflow: a write to cell c while loaded[c]=1 and no same-cycle promotion sets wt_ovf_err. It stays set until reset. The write still happens.
- Promotion (dat_in_pvld=1 and dat_in_pd[6]=1):
  - For each cell with loaded=1: active data and mask are copied from shadow, wt_act_vld[c] is set, loaded[c] is cleared.
  - Unloaded cells keep their active contents and their wt_act_vld.
- Simultaneous weight write and promotion to the same cell:
  - Promotion takes the pre-write shadow contents.
  - The new write then lands, and loaded ends at 1.
  - No error is raised.
- Data path, 1-cycle latency:
  - dat_out_pvld follows dat_in_pvld one cycle later.
  - pd and mask load only when dat_in_pvld=1.
  - Data element k loads only when dat_in_pvld and dat_in_mask[k] are both 1; otherwise it holds.
  - Downstream treats unmasked elements as don't-care.
- Alignment: active weights update on the same edge that registers the stripe_st beat. The beat on dat_out therefore sees the new weights.
- stripe_cnt:
  - +1 on a valid beat with pd[7]=1.
  - Cleared on a valid beat with pd[8]=1; clear wins over increment.
  - Wraps 2^CNT_W-1 to 0 silently.
- layer_end also clears wt_act_vld for all cells on the same edge. Any same-cycle promotion is applied first, then cleared.
- Reset mid-stream: all state is lost immediately. The first post-reset data beat sees wt_act_vld=0 and zero weights.

Test Plan:
- Reset, then write cell 0 with sel=4'b0001, mask=8'hFF, data bytes 0x01..0x08, then a data beat with pd=9'h040 -> one cycle later: dat_out_pvld=1, wt_act_vld=4'b0001, cell 0 active bytes 0x01..0x08, wt_ovf_err=0.
- Write cell 1 twice (data 0xAA then 0x55, mask 8'hFF) with no promotion between -> wt_ovf_err=1 and stays 1; the following promotion yields cell 1 = 0x55 in every byte.
- Write mask=8'h0F with data 0x11 to cell 2, whose shadow holds 0x22 -> after promotion: elements 0-3 = 0x11, elements 4-7 = 0x22, wt_act_mask cell 2 = 8'h0F.
- Same cycle: weight write 0x33 to cell 3 (shadow holds 0x44, loaded) plus promotion -> active = 0x44, loaded[3]=1, no error; the next promotion gives 0x33.
- Three beats with pd[7]=1, then one beat with pd=9'h180 -> stripe_cnt reads 1,2,3, then 0; wt_act_vld=0.
- Preload stripe_cnt at 16'hFFFF via a long run, then one beat with stripe_end -> stripe_cnt=0. Assert rstn mid-run -> all outputs 0 asynchronously.
